// File: rtl/axis_tft_pattern_gen_pkg.sv
// Shared constants for the TFT test-pattern source: pattern modes, FSM encoding
// and the colour-bar palette, plus the per-pixel colour function.
package tft_pattern_pkg;

  localparam logic [1:0] MODE_SOLID    = 2'd0;
  localparam logic [1:0] MODE_GRADIENT = 2'd1;
  localparam logic [1:0] MODE_BARS     = 2'd2;
  localparam logic [1:0] MODE_CHECKER  = 2'd3;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_LATCH      = 2'd1;
  localparam logic [1:0] ST_STREAM     = 2'd2;
  localparam logic [1:0] ST_FRAME_DONE = 2'd3;

  // Entry 0 is the leftmost bar (white); entry 7 (black) also covers the remainder pixels.
  localparam logic [7:0][23:0] BAR_TABLE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [23:0] pattern_pixel(
    input logic [1:0]  mode,
    input logic [7:0]  x_lo,
    input logic [7:0]  y_lo,
    input logic [2:0]  bar_idx,
    input logic [23:0] fg
  );
    logic [23:0] pix;
    pix = 24'h000000;
    case (mode)
      MODE_SOLID:    pix = fg;
      MODE_GRADIENT: pix = {x_lo, y_lo, 8'h00};
      MODE_BARS:     pix = BAR_TABLE[bar_idx];
      MODE_CHECKER:  pix = (x_lo[3] ^ y_lo[3]) ? fg : 24'h000000;
      default:       pix = 24'h000000;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/axis_tft_pattern_gen_if.sv
// AXI-Stream video link between the pattern source (master) and the TFT controller (slave).
interface axis_tft_pattern_gen_if #(
  parameter int AXIS_WIDTH = 24
);
  logic [AXIS_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;
  logic [3:0]            user;

  modport master (output data, output valid, output last, output user, input ready);
  modport slave  (input data, input valid, input last, input user, output ready);
endinterface

// File: rtl/axis_tft_pattern_gen.sv
// AXI-Stream RGB888 test-pattern generator: solid, gradient, colour bars and
// checkerboard frames of programmable size, fsync on user[0], end-of-line on last.
module axis_tft_pattern_gen
  import tft_pattern_pkg::*;
#(
  parameter int AXIS_WIDTH = 24,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic [1:0]           i_mode,
  input  logic [DIM_WIDTH-1:0] i_width,
  input  logic [DIM_WIDTH-1:0] i_height,
  input  logic [23:0]          i_fg_color,
  axis_tft_pattern_gen_if.master axis,
  output logic                 o_busy,
  output logic                 o_cfg_error,
  output logic [31:0]          o_frame_count
);

  logic [1:0]           state;
  logic [1:0]           cfg_mode;
  logic [DIM_WIDTH-1:0] cfg_width;
  logic [DIM_WIDTH-1:0] cfg_height;
  logic [23:0]          cfg_fg;
  logic [DIM_WIDTH-1:0] x;
  logic [DIM_WIDTH-1:0] y;
  logic [DIM_WIDTH-1:0] bar_cnt;
  logic [2:0]           bar_idx;

  logic [DIM_WIDTH-1:0] bar_w;
  logic [DIM_WIDTH-1:0] x_inc;
  logic [DIM_WIDTH-1:0] y_inc;
  logic [DIM_WIDTH-1:0] bar_cnt_next;
  logic [2:0]           bar_idx_next;
  logic                 end_of_line;
  logic                 end_of_frame;
  logic                 handshake;

  // Next-pixel bookkeeping: the outputs are registered, so the pixel after a
  // handshake is computed from the coordinates the counters are about to take.
  always_comb begin
    bar_w = cfg_width >> 3;
    if (bar_w == '0) bar_w = DIM_WIDTH'(1);
    x_inc        = x + 1'b1;
    y_inc        = y + 1'b1;
    end_of_line  = (x == cfg_width - 1'b1);
    end_of_frame = end_of_line && (y == cfg_height - 1'b1);
    handshake    = axis.valid && axis.ready;
    bar_cnt_next = bar_cnt + 1'b1;
    bar_idx_next = bar_idx;
    if (bar_cnt_next == bar_w) begin
      bar_cnt_next = '0;
      if (bar_idx != 3'd7) bar_idx_next = bar_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cfg_mode      <= MODE_SOLID;
      cfg_width     <= '0;
      cfg_height    <= '0;
      cfg_fg        <= '0;
      x             <= '0;
      y             <= '0;
      bar_cnt       <= '0;
      bar_idx       <= '0;
      axis.valid    <= 1'b0;
      axis.data     <= '0;
      axis.last     <= 1'b0;
      axis.user     <= 4'b0000;
      o_busy        <= 1'b0;
      o_cfg_error   <= 1'b0;
      o_frame_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_enable) begin
            state  <= ST_LATCH;
            o_busy <= 1'b1;
          end
        end

        // Configuration is taken here only; pixel (0,0) is built from the raw
        // inputs because the config registers load on this same edge.
        ST_LATCH: begin
          cfg_mode   <= i_mode;
          cfg_width  <= i_width;
          cfg_height <= i_height;
          cfg_fg     <= i_fg_color;
          x          <= '0;
          y          <= '0;
          bar_cnt    <= '0;
          bar_idx    <= '0;
          if (i_width == '0 || i_height == '0) begin
            o_cfg_error <= 1'b1;
            o_busy      <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            state      <= ST_STREAM;
            axis.valid <= 1'b1;
            axis.data  <= AXIS_WIDTH'(pattern_pixel(i_mode, 8'h00, 8'h00, 3'd0, i_fg_color));
            axis.last  <= (i_width == DIM_WIDTH'(1));
            axis.user  <= 4'b0001;
          end
        end

        ST_STREAM: begin
          if (handshake) begin
            axis.user <= 4'b0000;
            if (end_of_frame) begin
              state      <= ST_FRAME_DONE;
              axis.valid <= 1'b0;
              axis.last  <= 1'b0;
            end else if (end_of_line) begin
              x         <= '0;
              y         <= y_inc;
              bar_cnt   <= '0;
              bar_idx   <= '0;
              axis.data <= AXIS_WIDTH'(pattern_pixel(cfg_mode, 8'h00, y_inc[7:0], 3'd0, cfg_fg));
              axis.last <= (cfg_width == DIM_WIDTH'(1));
            end else begin
              x         <= x_inc;
              bar_cnt   <= bar_cnt_next;
              bar_idx   <= bar_idx_next;
              axis.data <= AXIS_WIDTH'(pattern_pixel(cfg_mode, x_inc[7:0], y[7:0], bar_idx_next, cfg_fg));
              axis.last <= (x_inc == cfg_width - 1'b1);
            end
          end
        end

        ST_FRAME_DONE: begin
          o_frame_count <= o_frame_count + 32'd1;
          if (i_enable) begin
            state <= ST_LATCH;
          end else begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_tft_pattern_gen.sv
// Directed self-checking bench for axis_tft_pattern_gen: each frame is compared
// beat by beat against an independent pixel model and hand-picked constants.
module tb_axis_tft_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] width = 16'd0;
  logic [15:0] height = 16'd0;
  logic [23:0] fg_color = 24'h000000;
  logic        busy;
  logic        cfg_error;
  logic [31:0] frame_count;

  int checks = 0;
  int errors = 0;

  logic [23:0] got_data[$];
  logic        got_last[$];

  axis_tft_pattern_gen_if #(.AXIS_WIDTH(24)) axis_bus ();

  axis_tft_pattern_gen #(.AXIS_WIDTH(24), .DIM_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (enable),
    .i_mode        (mode),
    .i_width       (width),
    .i_height      (height),
    .i_fg_color    (fg_color),
    .axis          (axis_bus),
    .o_busy        (busy),
    .o_cfg_error   (cfg_error),
    .o_frame_count (frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bars are located by division here, independent of the DUT's running counter.
  function automatic logic [23:0] expPixel(input int m, input int w, input int x, input int y, input logic [23:0] fg);
    int bw;
    int idx;
    logic [23:0] pix;
    pix = 24'h000000;
    case (m)
      0: pix = fg;
      1: pix = {x[7:0], y[7:0], 8'h00};
      2: begin
        bw = w / 8;
        if (bw == 0) bw = 1;
        idx = x / bw;
        if (idx > 7) idx = 7;
        case (idx)
          0: pix = 24'hFFFFFF;
          1: pix = 24'hFFFF00;
          2: pix = 24'h00FFFF;
          3: pix = 24'h00FF00;
          4: pix = 24'hFF00FF;
          5: pix = 24'hFF0000;
          6: pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      default: pix = (((x >> 3) ^ (y >> 3)) & 1) != 0 ? fg : 24'h000000;
    endcase
    return pix;
  endfunction

  task automatic resetDut();
    rst = 1'b1;
    enable = 1'b0;
    axis_bus.ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one frame; enable drops once drop_after beats have been accepted.
  task automatic applyStimulus(input string name, input int m, input int w, input int h,
                               input logic [23:0] fg, input bit toggle_ready, input int drop_after);
    int n;
    int first_valid;
    int extra;
    bit stalled;
    logic [23:0] prev_data;
    logic prev_last;
    logic [3:0] prev_user;
    got_data.delete();
    got_last.delete();
    mode = 2'(m);
    width = 16'(w);
    height = 16'(h);
    fg_color = fg;
    enable = 1'b1;
    n = 0;
    first_valid = -1;
    stalled = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    prev_user = '0;
    for (int cyc = 1; cyc <= 400 && n < w * h; cyc++) begin
      @(negedge clk);
      axis_bus.ready = toggle_ready ? cyc[0] : 1'b1;
      if (axis_bus.valid && first_valid < 0) first_valid = cyc;
      if (stalled) begin
        checkOutput({name, " hold data"}, 32'(axis_bus.data), 32'(prev_data));
        checkOutput({name, " hold last"}, 32'(axis_bus.last), 32'(prev_last));
        checkOutput({name, " hold user"}, 32'(axis_bus.user), 32'(prev_user));
      end
      stalled = axis_bus.valid && !axis_bus.ready;
      prev_data = axis_bus.data;
      prev_last = axis_bus.last;
      prev_user = axis_bus.user;
      if (axis_bus.valid && axis_bus.ready) begin
        got_data.push_back(axis_bus.data);
        got_last.push_back(axis_bus.last);
        checkOutput($sformatf("%s data[%0d]", name, n), 32'(axis_bus.data),
                    32'(expPixel(m, w, n % w, n / w, fg)));
        checkOutput($sformatf("%s last[%0d]", name, n), 32'(axis_bus.last), 32'((n % w) == w - 1));
        checkOutput($sformatf("%s user[%0d]", name, n), 32'(axis_bus.user), 32'(n == 0));
        n++;
        if (n == drop_after) enable = 1'b0;
      end
    end
    enable = 1'b0;
    axis_bus.ready = 1'b1;
    checkOutput({name, " start latency"}, 32'(first_valid), 32'd2);
    checkOutput({name, " beat count"}, 32'(n), 32'(w * h));
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (axis_bus.valid) extra++;
    end
    checkOutput({name, " extra beats"}, 32'(extra), 32'd0);
    checkOutput({name, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int valid_seen;
    int waited;
    axis_bus.ready = 1'b1;
    @(negedge clk);
    checkOutput("reset valid", 32'(axis_bus.valid), 32'd0);
    checkOutput("reset data", 32'(axis_bus.data), 32'd0);
    checkOutput("reset last", 32'(axis_bus.last), 32'd0);
    checkOutput("reset user", 32'(axis_bus.user), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset cfg_error", 32'(cfg_error), 32'd0);
    checkOutput("reset frame_count", frame_count, 32'd0);
    resetDut();

    applyStimulus("solid", 0, 4, 2, 24'h123456, 1'b0, 1);
    checkOutput("solid beat0", 32'(got_data[0]), 32'h123456);
    checkOutput("solid beat3 last", 32'(got_last[3]), 32'd1);
    checkOutput("solid frame_count", frame_count, 32'd1);

    resetDut();
    applyStimulus("bars", 2, 16, 1, 24'h000000, 1'b0, 1);
    checkOutput("bars px1", 32'(got_data[1]), 32'hFFFFFF);
    checkOutput("bars px2", 32'(got_data[2]), 32'hFFFF00);
    checkOutput("bars px9", 32'(got_data[9]), 32'hFF00FF);
    checkOutput("bars px15", 32'(got_data[15]), 32'h000000);
    checkOutput("bars px15 last", 32'(got_last[15]), 32'd1);

    resetDut();
    applyStimulus("bars20", 2, 20, 1, 24'h000000, 1'b0, 1);
    checkOutput("bars20 px13", 32'(got_data[13]), 32'h0000FF);
    checkOutput("bars20 px18", 32'(got_data[18]), 32'h000000);

    resetDut();
    applyStimulus("grad", 1, 3, 3, 24'h000000, 1'b1, 1);
    checkOutput("grad px1", 32'(got_data[1]), 32'h010000);
    checkOutput("grad px3", 32'(got_data[3]), 32'h000100);
    checkOutput("grad px8", 32'(got_data[8]), 32'h020200);

    resetDut();
    applyStimulus("checker", 3, 20, 9, 24'hA5A5A5, 1'b0, 1);
    checkOutput("checker px8", 32'(got_data[8]), 32'hA5A5A5);
    checkOutput("checker px168", 32'(got_data[168]), 32'h000000);

    resetDut();
    applyStimulus("drop", 0, 4, 4, 24'h00C0DE, 1'b0, 3);
    checkOutput("drop frame_count", frame_count, 32'd1);

    // Reset in the middle of a frame, with enable kept high across it.
    mode = 2'd0;
    width = 16'd4;
    height = 16'd4;
    fg_color = 24'hABCDEF;
    enable = 1'b1;
    axis_bus.ready = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("pre-rst valid", 32'(axis_bus.valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-rst valid", 32'(axis_bus.valid), 32'd0);
    checkOutput("mid-rst frame_count", frame_count, 32'd0);
    checkOutput("mid-rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!axis_bus.valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("post-rst latency", 32'(waited), 32'd1);
    checkOutput("post-rst user", 32'(axis_bus.user), 32'd1);
    checkOutput("post-rst data", 32'(axis_bus.data), 32'hABCDEF);
    enable = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("post-rst frame_count", frame_count, 32'd1);

    // Zero width must refuse to stream and latch the error flag.
    resetDut();
    width = 16'd0;
    height = 16'd2;
    enable = 1'b1;
    valid_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (axis_bus.valid) valid_seen++;
    end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("w0 valid beats", 32'(valid_seen), 32'd0);
    checkOutput("w0 cfg_error", 32'(cfg_error), 32'd1);
    checkOutput("w0 busy", 32'(busy), 32'd0);
    checkOutput("w0 frame_count", frame_count, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("w0 cfg_error sticky", 32'(cfg_error), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
